alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared multi-cycle ALU.
// Only one requester owns the ALU at a time. When both request together,
// a one-bit round-robin pointer breaks the tie. Operations with an illegal
// op code never reach the ALU and are answered at once with an error.
// A WAIT that runs TIMEOUT cycles without alu_done is answered with an error.
// TIMEOUT is valid over 2..255 so that the wait counter fits in 8 bits.
module alu_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  op0,
  input  logic [4:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_remainder,
  output logic        rsp_err,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_valid,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_remainder,
  input  logic        alu_done,
  output logic        busy
);

  // Highest legal op code (DIV). Code 0 and anything above this are rejected.
  localparam logic [4:0] OP_LAST   = 5'b10001;
  // The counter value on the final cycle a WAIT may last.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        ptr;        // requester that wins the next tie
  logic        grant_idx;  // requester that owns the current operation
  logic [7:0]  wait_cnt;   // WAIT cycles already spent without alu_done

  logic        grant_valid;
  logic        grant_sel;
  logic [4:0]  grant_op;
  logic [15:0] grant_a;
  logic [15:0] grant_b;
  logic        grant_legal;
  logic        timeout_hit;

  // Choose the requester to grant in IDLE and decode whether its op is legal.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    grant_valid = req0 | req1;
    grant_sel   = req1;
    if (req0 && req1) begin
      grant_sel = ptr;
    end
    grant_op    = grant_sel ? op1 : op0;
    grant_a     = grant_sel ? a1  : a0;
    grant_b     = grant_sel ? b1  : b0;
    grant_legal = (grant_op != 5'd0) && (grant_op <= OP_LAST);
  end

  // Last permitted WAIT cycle has passed with no completion from the ALU.
  assign timeout_hit = (state == S_WAIT) && !alu_done && (wait_cnt == WAIT_LAST);

  // State register; reset drops straight back to IDLE and abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state is written with <= so that every register samples
    // the values from before the edge, independent of statement order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          next_state = grant_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (alu_done || timeout_hit) begin
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes and status decoded from the current state and owner.
  always_comb begin
    alu_valid = (state == S_ISSUE);
    ack0      = (state == S_RESP) && !grant_idx;
    ack1      = (state == S_RESP) &&  grant_idx;
    busy      = (state != S_IDLE);
  end

  // Grant latch, wait counter, response capture and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here drives an output or steers arbitration, so all
    // of them are cleared by reset; nothing is left to power-up values.
    if (rst) begin
      ptr           <= 1'b0;
      grant_idx     <= 1'b0;
      wait_cnt      <= 8'd0;
      alu_op        <= 5'd0;
      alu_a         <= 16'd0;
      alu_b         <= 16'd0;
      rsp_result    <= 16'd0;
      rsp_remainder <= 16'd0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            alu_op    <= grant_op;
            alu_a     <= grant_a;
            alu_b     <= grant_b;
            grant_idx <= grant_sel;
            // An illegal op is answered without touching the ALU.
            if (!grant_legal) begin
              rsp_result    <= 16'd0;
              rsp_remainder <= 16'd0;
              rsp_err       <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= 8'd0;
        end
        S_WAIT: begin
          // alu_done takes priority, even on the last permitted cycle.
          if (alu_done) begin
            rsp_result    <= alu_result;
            rsp_remainder <= alu_remainder;
            rsp_err       <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              rsp_result    <= 16'd0;
              rsp_remainder <= 16'd0;
              rsp_err       <= 1'b1;
            end
          end
        end
        S_RESP: begin
          // The requester just served loses the next tie.
          ptr <= ~grant_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model of arbitration order, latency and response values.
// The bench acts as the ALU: it answers alu_valid after a chosen delay.
module tb_alu_arbiter;

  localparam int TO = 4;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd17;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [4:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [15:0] rsp_result, rsp_remainder;
  logic        rsp_err;
  logic [4:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_valid;
  logic [15:0] alu_result, alu_remainder;
  logic        alu_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          ack_cyc;
    int          valid_cyc;
    int          valid_cnt;
    logic        ack0;
    logic        ack1;
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } obs_t;

  typedef struct {
    int          ack_cyc;
    int          valid_cnt;
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
  } exp_t;

  alu_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .req1          (req1),
    .op0           (op0),
    .op1           (op1),
    .a0            (a0),
    .b0            (b0),
    .a1            (a1),
    .b1            (b1),
    .ack0          (ack0),
    .ack1          (ack1),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_valid     (alu_valid),
    .alu_result    (alu_result),
    .alu_remainder (alu_remainder),
    .alu_done      (alu_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behaviour of the ALU the bench pretends to be: {remainder, result}.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [15:0] m;
    r = 16'd0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = a ^ ~b;
    endcase
    m = ~r;
    if (op == OP_DIV) begin
      if (b == 16'd0) begin
        r = 16'hffff;
        m = a;
      end else begin
        r = a / b;
        m = a % b;
      end
    end
    return {m, r};
  endfunction

  // Expected outcome of one granted request whose ALU answers n WAIT cycles in.
  function automatic exp_t predict(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int n);
    exp_t e;
    if (op == 5'd0 || op > 5'd17) begin
      e.ack_cyc = 1; e.valid_cnt = 0; e.res = 16'd0; e.rem = 16'd0; e.err = 1'b1;
    end else if (n <= TO) begin
      e.ack_cyc = n + 2; e.valid_cnt = 1; {e.rem, e.res} = alu_fn(op, a, b); e.err = 1'b0;
    end else begin
      e.ack_cyc = TO + 2; e.valid_cnt = 1; e.res = 16'd0; e.rem = 16'd0; e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [4:0] rand_op();
    logic [4:0] legal [7];
    legal = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_DIV};
    if ($urandom_range(0, 9) < 7) return legal[$urandom_range(0, 6)];
    if ($urandom_range(0, 2) == 0) return 5'd0;
    return 5'($urandom_range(18, 31));
  endfunction

  // Runs one transaction. The current negedge is cycle 0 (IDLE, requests set).
  // The ALU answers n cycles after alu_valid; noise adds alu_done pulses in
  // the IDLE and ISSUE cycles, which must be ignored. Returns observations only.
  task automatic serve(input int n, input bit noise, output obs_t o);
    o = '{ack_cyc: -1, valid_cyc: -1, valid_cnt: 0, ack0: 1'b0, ack1: 1'b0,
          res: 16'd0, rem: 16'd0, err: 1'b0, op: 5'd0, a: 16'd0, b: 16'd0};
    alu_done      = noise;
    alu_result    = 16'hdead;
    alu_remainder = 16'hbeef;
    for (int c = 1; c <= 3 * TO + 20; c++) begin
      @(negedge clk);
      if (alu_valid) begin
        o.valid_cnt++;
        if (o.valid_cyc < 0) begin
          o.valid_cyc = c;
          o.op = alu_op; o.a = alu_a; o.b = alu_b;
        end
      end
      if (ack0 || ack1) begin
        o.ack_cyc = c; o.ack0 = ack0; o.ack1 = ack1;
        o.res = rsp_result; o.rem = rsp_remainder; o.err = rsp_err;
        alu_done = 1'b0;
        break;
      end
      if (o.valid_cyc > 0 && c == o.valid_cyc + n) begin
        {alu_remainder, alu_result} = alu_fn(alu_op, alu_a, alu_b);
        alu_done = 1'b1;
      end else if (alu_valid && noise) begin
        alu_result = 16'hdead; alu_remainder = 16'hbeef;
        alu_done = 1'b1;
      end else begin
        alu_done = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 5'd0; op1 = 5'd0;
    a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0;
    alu_done = 1'b0; alu_result = 16'd0; alu_remainder = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, alu_valid, busy, rsp_err} !== 5'b0 || rsp_result !== 16'd0 || rsp_remainder !== 16'd0 ||
        alu_op !== 5'd0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: ack=%b%b valid=%b busy=%b err=%b res=%h rem=%h op=%h a=%h b=%h, expected all zero",
               ack0, ack1, alu_valid, busy, rsp_err, rsp_result, rsp_remainder, alu_op, alu_a, alu_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    obs_t o;
    req0 = 1'b1; op0 = OP_ADD; a0 = 16'd10; b0 = 16'd5;
    serve(1, 1'b0, o);
    req0 = 1'b0; op0 = OP_SUB; a0 = 16'd99; b0 = 16'd1;
    checks++;
    if (o.valid_cyc !== 1 || o.ack_cyc !== 3 || {o.ack1, o.ack0} !== 2'b01) begin
      errors++;
      $display("FAIL add_latency: valid@%0d ack@%0d ack1/0=%b%b, expected valid@1 ack@3 ack0", o.valid_cyc, o.ack_cyc, o.ack1, o.ack0);
    end
    checks++;
    if (o.res !== 16'd15 || o.err !== 1'b0 || o.op !== OP_ADD || o.a !== 16'd10 || o.b !== 16'd5) begin
      errors++;
      $display("FAIL add_result: res=%0d err=%b op=%h a=%0d b=%0d, expected 15 0 01 10 5", o.res, o.err, o.op, o.a, o.b);
    end
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || alu_op !== OP_ADD || alu_a !== 16'd10 || rsp_result !== 16'd15) begin
      errors++;
      $display("FAIL add_hold: ack0=%b busy=%b op=%h a=%0d res=%0d, expected 0 0 01 10 15", ack0, busy, alu_op, alu_a, rsp_result);
    end
  endtask

  task automatic test_priority();
    obs_t o;
    rst = 1'b1;
    req0 = 1'b1; op0 = OP_DIV; a0 = 16'd15; b0 = 16'd7;
    req1 = 1'b1; op1 = OP_AND; a1 = 16'd15; b1 = 16'd7;
    @(negedge clk);
    rst = 1'b0;
    serve(2, 1'b0, o);
    checks++;
    if ({o.ack1, o.ack0} !== 2'b01 || o.res !== 16'd2 || o.rem !== 16'd1 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL prio_first: ack1/0=%b%b res=%0d rem=%0d err=%b, expected 01 2 1 0", o.ack1, o.ack0, o.res, o.rem, o.err);
    end
    // requester 0 stays high with a new op: a fresh tie, now won by requester 1
    op0 = OP_ADD; a0 = 16'd1; b0 = 16'd2;
    @(negedge clk);
    serve(1, 1'b0, o);
    req1 = 1'b0;
    checks++;
    if ({o.ack1, o.ack0} !== 2'b10 || o.res !== 16'd7 || o.ack_cyc !== 3) begin
      errors++;
      $display("FAIL prio_second: ack1/0=%b%b res=%0d ack@%0d, expected 10 7 3", o.ack1, o.ack0, o.res, o.ack_cyc);
    end
    @(negedge clk);
    serve(1, 1'b0, o);
    req0 = 1'b0;
    checks++;
    if ({o.ack1, o.ack0} !== 2'b01 || o.res !== 16'd3) begin
      errors++;
      $display("FAIL prio_held: ack1/0=%b%b res=%0d, expected 01 3", o.ack1, o.ack0, o.res);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [4:0] bad_op [3];
    logic       bad_who [3];
    bad_op  = '{5'b10101, 5'b00000, 5'b10010};
    bad_who = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      req0 = !bad_who[i]; op0 = bad_op[i]; a0 = 16'd3; b0 = 16'd4;
      req1 =  bad_who[i]; op1 = bad_op[i]; a1 = 16'd3; b1 = 16'd4;
      serve(1, 1'b1, o);
      checks++;
      if (o.valid_cnt !== 0 || o.ack_cyc !== 1 || o.ack1 !== bad_who[i] || o.ack0 !== !bad_who[i] ||
          o.err !== 1'b1 || o.res !== 16'd0 || o.rem !== 16'd0 || alu_op !== bad_op[i]) begin
        errors++;
        $display("FAIL illegal_op_%b: valids=%0d ack@%0d ack1/0=%b%b err=%b res=%h rem=%h alu_op=%b, expected 0 1 requester %0d 1 0 0",
                 bad_op[i], o.valid_cnt, o.ack_cyc, o.ack1, o.ack0, o.err, o.res, o.rem, alu_op, bad_who[i]);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    int   n_tab [4];
    bit   stray;
    n_tab = '{TO + 2, TO, TO - 1, 1};
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; op0 = OP_MUL; a0 = 16'd3; b0 = 16'd4;
      e = predict(OP_MUL, 16'd3, 16'd4, n_tab[i]);
      serve(n_tab[i], 1'b0, o);
      req0 = 1'b0;
      checks++;
      if (o.ack_cyc !== e.ack_cyc || o.ack0 !== 1'b1 || o.err !== e.err || o.res !== e.res || o.rem !== e.rem) begin
        errors++;
        $display("FAIL timeout_n%0d: ack@%0d ack0=%b err=%b res=%h rem=%h, expected ack@%0d 1 %b %h %h",
                 n_tab[i], o.ack_cyc, o.ack0, o.err, o.res, o.rem, e.ack_cyc, e.err, e.res, e.rem);
      end
      @(negedge clk);
      if (i == 0) begin
        // the abandoned operation completes late, while the arbiter is idle
        stray = 1'b0;
        alu_done = 1'b1; alu_result = 16'h1234; alu_remainder = 16'h5678;
        repeat (2) begin
          @(negedge clk);
          stray |= ack0 | ack1 | busy;
        end
        alu_done = 1'b0;
        checks++;
        if (stray !== 1'b0 || rsp_result !== 16'd0 || rsp_remainder !== 16'd0 || rsp_err !== 1'b1) begin
          errors++;
          $display("FAIL timeout_late_done: activity=%b res=%h rem=%h err=%b, expected 0 0 0 1",
                   stray, rsp_result, rsp_remainder, rsp_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   stray;
    req0 = 1'b1; op0 = OP_MUL; a0 = 16'd10; b0 = 16'd5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_wait: busy=%b valid=%b, expected 1 0", busy, alu_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || alu_op !== 5'd0 || alu_a !== 16'd0 || rsp_result !== 16'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b ack0=%b op=%h a=%h res=%h err=%b, expected all zero",
               busy, ack0, alu_op, alu_a, rsp_result, rsp_err);
    end
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    alu_done = 1'b1; alu_result = 16'd50; alu_remainder = 16'd9;
    stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      stray |= ack0 | ack1 | busy;
    end
    alu_done = 1'b0;
    checks++;
    if (stray !== 1'b0 || rsp_result !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_stale_done: activity=%b res=%h, expected 0 0", stray, rsp_result);
    end
    req0 = 1'b1;
    serve(2, 1'b0, o);
    req0 = 1'b0;
    checks++;
    if (o.ack_cyc !== 4 || o.ack0 !== 1'b1 || o.res !== 16'd50 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_retry: ack@%0d ack0=%b res=%0d err=%b, expected 4 1 50 0", o.ack_cyc, o.ack0, o.res, o.err);
    end
    @(negedge clk);
  endtask

  // Random request patterns served back to back; order from a round-robin model.
  task automatic test_back_to_back();
    obs_t        o;
    exp_t        e;
    logic [4:0]  mop [2];
    logic [15:0] ma [2];
    logic [15:0] mb [2];
    bit          pend [2];
    logic        ptr_m;
    logic        win;
    int          n;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 1'b0;
    pend = '{1'b0, 1'b0};
    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1'b1;
          mop[k] = rand_op(); ma[k] = 16'($urandom); mb[k] = 16'($urandom_range(0, 300));
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        mop[0] = rand_op(); ma[0] = 16'($urandom); mb[0] = 16'($urandom_range(1, 300));
      end
      req0 = pend[0]; op0 = mop[0]; a0 = ma[0]; b0 = mb[0];
      req1 = pend[1]; op1 = mop[1]; a1 = ma[1]; b1 = mb[1];
      win = (pend[0] && pend[1]) ? ptr_m : pend[1];
      n = $urandom_range(1, TO + 2);
      e = predict(mop[win], ma[win], mb[win], n);
      serve(n, 1'($urandom_range(0, 1)), o);
      checks++;
      if (o.ack_cyc !== e.ack_cyc || {o.ack1, o.ack0} !== (win ? 2'b10 : 2'b01) || o.valid_cnt !== e.valid_cnt) begin
        errors++;
        $display("FAIL rand%0d_order: ack@%0d ack1/0=%b%b valids=%0d, expected ack@%0d requester %0d valids=%0d",
                 r, o.ack_cyc, o.ack1, o.ack0, o.valid_cnt, e.ack_cyc, win, e.valid_cnt);
      end
      checks++;
      if (o.res !== e.res || o.rem !== e.rem || o.err !== e.err) begin
        errors++;
        $display("FAIL rand%0d_rsp: res=%h rem=%h err=%b, expected %h %h %b", r, o.res, o.rem, o.err, e.res, e.rem, e.err);
      end
      if (e.valid_cnt == 1) begin
        checks++;
        if (o.op !== mop[win] || o.a !== ma[win] || o.b !== mb[win]) begin
          errors++;
          $display("FAIL rand%0d_operands: op=%h a=%h b=%h, expected %h %h %h", r, o.op, o.a, o.b, mop[win], ma[win], mb[win]);
        end
      end
      pend[win] = 1'b0;
      ptr_m = ~win;
      if (win) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_idle: ack1/0=%b%b busy=%b, expected 00 0", r, ack1, ack0, busy);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_add();
    test_priority();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
